// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: pipeline port 0 has priority, while long-latency port 1 is
// buffered in a small FIFO. A starvation counter forces a FIFO drain after STARVE_LIMIT denials.
module reg_wb_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     p0_valid,
  input  logic [4:0]               p0_addr,
  input  logic [31:0]              p0_data,
  output logic                     p0_ready,
  input  logic                     p1_valid,
  input  logic [4:0]               p1_addr,
  input  logic [31:0]              p1_data,
  output logic                     p1_ready,
  output logic [$clog2(DEPTH):0]   p1_count,
  input  logic [4:0]               query_addr,
  output logic                     query_pending,
  output logic                     reg_write,
  output logic [4:0]               reg_write_addr,
  output logic [31:0]              reg_write_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  logic            fifo_empty;
  logic            force_p1;
  logic            push;
  logic            grant_p0;
  logic            grant_p1;
  wb_req_t         grant_req;

  // Arbitration: a starved FIFO head beats p0; otherwise p0 wins, and the FIFO takes idle cycles.
  assign fifo_empty = (count == '0);
  assign force_p1   = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign p0_ready   = !force_p1;
  assign p1_ready   = (count < CW'(DEPTH));
  assign push       = p1_valid && p1_ready;
  assign grant_p1   = force_p1 || (!p0_valid && !fifo_empty);
  assign grant_p0   = p0_valid && !force_p1;
  assign grant_req  = grant_p1 ? mem[rd_ptr] : wb_req_t'{addr: p0_addr, data: p0_data};
  assign p1_count   = count;

  // FIFO storage is not reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wb_req_t'{addr: p1_addr, data: p1_data};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (grant_p1) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, grant_p1})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (fifo_empty || grant_p1) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  // Registered write port; register 0 is consumed but never written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
    end else if (grant_p0 || grant_p1) begin
      reg_write      <= (grant_req.addr != 5'd0);
      reg_write_addr <= grant_req.addr;
      reg_write_data <= grant_req.data;
    end else begin
      reg_write      <= 1'b0;
    end
  end

  // Pending-write lookup across live FIFO entries and the write in flight to the register file.
  always_comb begin : pending_lookup
    logic          hit;
    logic [AW-1:0] idx;
    logic [AW-1:0] offset;
    hit    = reg_write && (reg_write_addr == query_addr);
    idx    = '0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx    = AW'(i);
      offset = idx - rd_ptr;
      if ((CW'(offset) < count) && (mem[idx].addr == query_addr)) begin
        hit = 1'b1;
      end
    end
    query_pending = (query_addr != 5'd0) && hit;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: a queue-based reference model predicts handshakes,
// occupancy and pending lookups each cycle, and expected register writes are queued at grant time.
module tb_reg_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic [4:0]  p0_addr, p1_addr, query_addr;
  logic [31:0] p0_data, p1_data;
  logic        p0_ready, p1_ready, query_pending, reg_write;
  logic [1:0]  p1_count;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;

  reg_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .p1_count(p1_count), .query_addr(query_addr), .query_pending(query_pending),
    .reg_write(reg_write), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          first_stall = -1;
  int unsigned p0_gap = 0;
  int unsigned p1_gap = 0;
  bit          rand_q = 1'b0;
  logic [4:0]  q_fixed = 5'd0;

  logic [36:0] p0_q[$];
  logic [36:0] p1_q[$];
  logic [36:0] m_fifo[$];
  logic [36:0] sb[$];
  logic [4:0]  wr_log[$];
  int          m_starve;
  bit          m_wr;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete(); sb.delete(); p0_q.delete(); p1_q.delete();
    m_starve = 0; m_wr = 1'b0; m_addr = 5'd0; m_data = 32'd0;
  endtask

  // One clock: drive, compare at the falling edge, advance the model, return after the rising edge.
  task automatic cycle();
    bit          v0, v1, frc, hit, gp0, gp1, acc1;
    logic [36:0] e0, e1, g, e;
    e0 = (p0_q.size() > 0) ? p0_q[0] : 37'd0;
    e1 = (p1_q.size() > 0) ? p1_q[0] : 37'd0;
    v0 = (p0_q.size() > 0) && ($urandom_range(99) >= p0_gap);
    v1 = (p1_q.size() > 0) && ($urandom_range(99) >= p1_gap);
    p0_valid = v0; p0_addr = e0[36:32]; p0_data = e0[31:0];
    p1_valid = v1; p1_addr = e1[36:32]; p1_data = e1[31:0];
    query_addr = rand_q ? 5'($urandom_range(7)) : q_fixed;
    @(negedge clock);
    frc = (m_fifo.size() != 0) && (m_starve == int'(LIMIT));
    hit = m_wr && (m_addr == query_addr);
    foreach (m_fifo[i]) if (m_fifo[i][36:32] == query_addr) hit = 1'b1;
    if (query_addr == 5'd0) hit = 1'b0;
    check("p0_ready", 32'(p0_ready), 32'(!frc));
    check("p1_ready", 32'(p1_ready), 32'(m_fifo.size() < int'(DEPTH)));
    check("p1_count", 32'(p1_count), 32'(m_fifo.size()));
    check("query_pending", 32'(query_pending), 32'(hit));
    check("reg_write", 32'(reg_write), 32'(m_wr));
    check("hold_addr", 32'(reg_write_addr), 32'(m_addr));
    check("hold_data", reg_write_data, m_data);
    if (reg_write) begin
      wr_log.push_back(reg_write_addr);
      if (sb.size() == 0) begin
        check("sb_unexpected_write", 32'(reg_write), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_addr", 32'(reg_write_addr), 32'(e[36:32]));
        check("sb_data", reg_write_data, e[31:0]);
      end
    end
    if (!p0_ready && first_stall < 0) first_stall = cyc;
    gp1  = frc || (!v0 && m_fifo.size() != 0);
    gp0  = v0 && !frc;
    acc1 = v1 && (m_fifo.size() < int'(DEPTH));
    g = 37'd0;
    if (gp1) begin
      g = m_fifo.pop_front();
      m_starve = 0;
    end else begin
      if (m_fifo.size() == 0) m_starve = 0;
      else if (m_starve < int'(LIMIT)) m_starve++;
      if (gp0) g = e0;
    end
    if (acc1) m_fifo.push_back(e1);
    if (gp0 || gp1) begin
      m_wr = (g[36:32] != 5'd0); m_addr = g[36:32]; m_data = g[31:0];
      if (m_wr) sb.push_back(g);
    end else begin
      m_wr = 1'b0;
    end
    if (gp0) void'(p0_q.pop_front());
    if (acc1) void'(p1_q.pop_front());
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input int max_cyc);
    int n = 0;
    while ((p0_q.size() + p1_q.size() + m_fifo.size()) != 0 && n < max_cyc) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(n < max_cyc), 32'd1);
    cycle(); cycle();
  endtask

  task automatic check_log(input string tag, input logic [4:0] exp[$]);
    check({tag, "_len"}, 32'(wr_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
      check({tag, "_order"}, 32'(wr_log[i]), 32'(exp[i]));
    wr_log.delete();
  endtask

  initial begin
    logic [4:0] exp[$];
    logic [4:0] p1_only[$];
    model_reset();
    // Reset with requests presented: nothing may be accepted.
    reset = 1'b1; p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'h1;
    p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'h2; query_addr = 5'd9;
    repeat (2) @(posedge clock);
    #1;
    check("rst_p0_ready", 32'(p0_ready), 32'd1);
    check("rst_p1_ready", 32'(p1_ready), 32'd1);
    check("rst_p1_count", 32'(p1_count), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_query", 32'(query_pending), 32'd0);
    check("rst_wr_addr", 32'(reg_write_addr), 32'd0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    reset = 1'b0;
    run_idle(10);
    check_log("after_reset", exp);

    // p0 only
    p0_q.push_back({5'd5, 32'hDEADBEEF});
    run_idle(20);
    exp = '{5'd5};
    check_log("p0_only", exp);

    // p1 only, with a lookup on its destination
    q_fixed = 5'd7;
    p1_q.push_back({5'd7, 32'h00000011});
    run_idle(20);
    exp = '{5'd7};
    check_log("p1_only", exp);

    // Starvation: p0 saturating while one FIFO entry waits
    q_fixed = 5'd3;
    first_stall = -1;
    begin
      int start;
      start = cyc;
      p1_q.push_back({5'd3, 32'h33});
      foreach (exp[i]) exp.delete();
      exp = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd12};
      foreach (exp[i]) p0_q.push_back({exp[i], 32'hA0 + 32'(i)});
      run_idle(40);
      check("stall_cycle", 32'(first_stall - start), 32'd5);
    end
    exp = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd3, 5'd12};
    check_log("starve", exp);

    // Full FIFO behind a saturating p0
    q_fixed = 5'd11;
    for (int i = 0; i < 8; i++) p0_q.push_back({5'(20 + i), 32'(i)});
    p1_q.push_back({5'd9, 32'h9}); p1_q.push_back({5'd10, 32'hA}); p1_q.push_back({5'd11, 32'hB});
    run_idle(60);
    check("full_total", 32'(wr_log.size()), 32'd11);
    foreach (wr_log[i]) if (wr_log[i] >= 5'd9 && wr_log[i] <= 5'd11) p1_only.push_back(wr_log[i]);
    wr_log.delete();
    wr_log = p1_only;
    exp = '{5'd9, 5'd10, 5'd11};
    check_log("full_order", exp);

    // Register 0 is consumed on both ports without a write
    q_fixed = 5'd0;
    p0_q.push_back({5'd0, 32'hFFFFFFFF}); p0_q.push_back({5'd0, 32'h1});
    p1_q.push_back({5'd0, 32'h5});
    run_idle(30);
    exp.delete();
    check_log("zero_reg", exp);

    // Randomised traffic with gaps and random lookups
    rand_q = 1'b1; p0_gap = 30; p1_gap = 40;
    for (int i = 0; i < 80; i++) p0_q.push_back({5'($urandom_range(7)), 32'($urandom)});
    for (int i = 0; i < 50; i++) p1_q.push_back({5'($urandom_range(7)), 32'($urandom)});
    run_idle(2000);
    wr_log.delete();
    rand_q = 1'b0; p0_gap = 0; p1_gap = 0;

    // Reset mid-operation with two entries queued
    q_fixed = 5'd13;
    for (int i = 0; i < 6; i++) p0_q.push_back({5'(16 + i), 32'(i)});
    p1_q.push_back({5'd13, 32'hD}); p1_q.push_back({5'd14, 32'hE});
    cycle(); cycle();
    check("pre_reset_count", 32'(p1_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_reg_write", 32'(reg_write), 32'd0);
    check("mid_rst_count", 32'(p1_count), 32'd0);
    check("mid_rst_p1_ready", 32'(p1_ready), 32'd1);
    check("mid_rst_query", 32'(query_pending), 32'd0);
    model_reset();
    p0_valid = 1'b0; p1_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    wr_log.delete();
    repeat (6) cycle();
    exp.delete();
    check_log("post_reset", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
